// File: rtl/bus_mem_responder.sv
// Purpose : memory-side responder on the snooping coherence bus; commits WriteBacks, answers ReadMisses with ReadHit data.
// Latency : ReadMiss sampled while idle -> reply on bus_out LATENCY cycles later, held for one cycle; replies spaced >= LATENCY+2.
// Backpr. : no backpressure on bus_in; up to two reads queue behind the active one, further reads are dropped and flag overflow.
//
// Ports:
//   clock     rising-edge system clock
//   resetn    asynchronous active-low reset (clears FSM, queue, store, flags)
//   bus_in    snooped bus message {msg, tag, value}; msg 2'b00 = idle
//   bus_out   reply message {ReadHit, tag, data}; all zeros when not replying
//   busy      a read is in flight or queued
//   overflow  sticky: a ReadMiss was dropped because the queue was full
//   rd_cnt / wb_cnt  (only with MEM_RESP_STATS_EN defined) wrapping counts of
//                    replies sent and WriteBacks sampled
module bus_mem_responder #(
    parameter int TAG_W   = 3,
    parameter int DATA_W  = 4,
    parameter int LATENCY = 2
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic [2+TAG_W+DATA_W-1:0] bus_in,
    output logic [2+TAG_W+DATA_W-1:0] bus_out,
    output logic                      busy,
    output logic                      overflow
`ifdef MEM_RESP_STATS_EN
    ,
    output logic [7:0]                rd_cnt,
    output logic [7:0]                wb_cnt
`endif
);

    localparam int BUS_W = 2 + TAG_W + DATA_W;
    localparam int DEPTH = 2 ** TAG_W;

    localparam logic [1:0] READ_MISS  = 2'b01;
    localparam logic [1:0] READ_HIT   = 2'b10;
    localparam logic [1:0] WRITE_BACK = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        REPLY = 2'd2
    } state_t;

    // Bus message fields
    logic [1:0]        in_msg;
    logic [TAG_W-1:0]  in_tag;
    logic [DATA_W-1:0] in_val;
    logic              rd_req;
    logic              wb_req;

    assign in_msg = bus_in[BUS_W-1 -: 2];
    assign in_tag = bus_in[DATA_W +: TAG_W];
    assign in_val = bus_in[DATA_W-1:0];
    assign rd_req = (in_msg == READ_MISS);
    assign wb_req = (in_msg == WRITE_BACK);

    // Backing store
    logic [DATA_W-1:0] mem [DEPTH];

    // FSM state
    state_t            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic [TAG_W-1:0]  cur_tag, cur_tag_nxt;

    // Two-entry pending queue
    logic [TAG_W-1:0]  q_tag [2];
    logic              rd_ptr;
    logic [1:0]        q_count;
    logic              wr_idx;
    logic              pop;
    logic              bypass;
    logic              push;
    logic              push_ok;
    logic              drop;

    // With a pop in the same cycle as a push into a full queue, the write lands
    // in the slot being vacated; its old value is consumed combinationally.
    assign wr_idx  = rd_ptr ^ q_count[0];
    assign push    = rd_req & ~bypass;
    assign drop    = push & (q_count == 2'd2) & ~pop;
    assign push_ok = push & ~drop;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        cur_tag_nxt = cur_tag;
        pop         = 1'b0;
        bypass      = 1'b0;
        case (state)
            IDLE: begin
                // Queued work takes priority; a fresh request only skips the
                // queue when nothing is waiting ahead of it.
                if (q_count != 2'd0) begin
                    pop         = 1'b1;
                    cur_tag_nxt = q_tag[rd_ptr];
                    cnt_nxt     = 4'(LATENCY);
                    state_nxt   = WAIT;
                end else if (rd_req) begin
                    bypass      = 1'b1;
                    cur_tag_nxt = in_tag;
                    cnt_nxt     = 4'(LATENCY);
                    state_nxt   = WAIT;
                end
            end
            WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_nxt = REPLY;
                end
            end
            REPLY: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            cur_tag <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            cur_tag <= cur_tag_nxt;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            q_tag[0] <= '0;
            q_tag[1] <= '0;
            rd_ptr   <= 1'b0;
            q_count  <= 2'd0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                q_tag[wr_idx] <= in_tag;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push_ok, pop})
                2'b10:   q_count <= q_count + 2'd1;
                2'b01:   q_count <= q_count - 2'd1;
                default: q_count <= q_count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wb_req) begin
            mem[in_tag] <= in_val;
        end
    end

    // Store is read live during REPLY so a WriteBack landing in WAIT is seen.
    always_comb begin
        bus_out = '0;
        if (state == REPLY) begin
            bus_out = {READ_HIT, cur_tag, mem[cur_tag]};
        end
    end

    assign busy = (state != IDLE) | (q_count != 2'd0);

`ifdef MEM_RESP_STATS_EN
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rd_cnt <= 8'd0;
            wb_cnt <= 8'd0;
        end else begin
            if (state == REPLY) begin
                rd_cnt <= rd_cnt + 8'd1;
            end
            if (wb_req) begin
                wb_cnt <= wb_cnt + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bus_mem_responder.sv
// Purpose : self-checking bench for bus_mem_responder against a transaction-level reference model.
// Latency : model predicts the reply edge and data for every ReadMiss from the bus timing rules.
// Backpr. : none; stimulus is driven every cycle, outputs sampled 1 ns after each rising edge.
module tb_bus_mem_responder;

    localparam int L = 2;

    logic       clock = 1'b0;
    logic       resetn;
    logic [8:0] bus_in;
    logic [8:0] bus_out;
    logic       busy;
    logic       overflow;
`ifdef MEM_RESP_STATS_EN
    logic [7:0] rd_cnt;
    logic [7:0] wb_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    bus_mem_responder #(.TAG_W(3), .DATA_W(4), .LATENCY(L)) dut (
        .clock    (clock),
        .resetn   (resetn),
        .bus_in   (bus_in),
        .bus_out  (bus_out),
        .busy     (busy),
        .overflow (overflow)
`ifdef MEM_RESP_STATS_EN
        ,
        .rd_cnt   (rd_cnt),
        .wb_cnt   (wb_cnt)
`endif
    );

    // ---------------- reference model ----------------
    // The responder is a single server: a job started at edge s replies at
    // edge s+L, and the server can start the next job at edge reply+2.
    logic [3:0] m_mem [8];
    logic [2:0] m_q [$];
    logic [2:0] m_cur;
    int         m_t;
    int         m_reply;
    logic       exp_ovf;
    logic       exp_busy;
    logic [8:0] exp_bus;
    logic [7:0] m_rd;
    logic [7:0] m_wb;

    function automatic logic [8:0] msg(input logic [1:0] code, input int tag, input int val);
        msg = {code, 3'(tag), 4'(val)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_mem[i] = 4'h0;
        m_q.delete();
        m_cur    = 3'd0;
        m_t      = 0;
        m_reply  = -100;
        exp_ovf  = 1'b0;
        exp_busy = 1'b0;
        exp_bus  = 9'd0;
        m_rd     = 8'd0;
        m_wb     = 8'd0;
    endtask

    task automatic model_edge(input logic [8:0] b);
        logic [1:0] code;
        logic [2:0] tag;
        logic       idle;
        logic       bypassed;
        code     = b[8:7];
        tag      = b[6:4];
        idle     = (m_t >= m_reply + 2);
        bypassed = 1'b0;
        if (code == 2'b11) begin
            m_mem[tag] = b[3:0];
            m_wb       = m_wb + 8'd1;
        end
        if (idle && m_q.size() > 0) begin
            m_cur   = m_q.pop_front();
            m_reply = m_t + L;
        end else if (idle && code == 2'b01) begin
            m_cur    = tag;
            m_reply  = m_t + L;
            bypassed = 1'b1;
        end
        if (code == 2'b01 && !bypassed) begin
            if (m_q.size() < 2) m_q.push_back(tag);
            else exp_ovf = 1'b1;
        end
        if (m_t == m_reply) begin
            exp_bus = {2'b10, m_cur, m_mem[m_cur]};
            m_rd    = m_rd + 8'd1;
        end else begin
            exp_bus = 9'd0;
        end
        exp_busy = (m_t <= m_reply) || (m_q.size() > 0);
        m_t++;
    endtask

    task automatic tick(input logic [8:0] b);
        bus_in = b;
        @(posedge clock);
        model_edge(b);
        #1;
        bus_in = 9'd0;
    endtask

    task automatic do_reset();
        bus_in = 9'd0;
        resetn = 1'b0;
        #3;
        resetn = 1'b1;
        model_reset();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bus_in = 9'd0;
        resetn = 1'b0;
        model_reset();
        #2;
        n_checks++;
        if (bus_out !== 9'd0 || busy !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_initial: got bus_out=%b busy=%b ovf=%b, want 0/0/0", bus_out, busy, overflow);
        end
        #1 resetn = 1'b1;
        @(posedge clock); #1;
        tick(msg(2'b11, 3, 15));
        tick(msg(2'b01, 5, 0));
        // now mid-WAIT: assert reset away from any edge
        #2 resetn = 1'b0;
        #1;
        n_checks++;
        if (bus_out !== 9'd0 || busy !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_wait: got bus_out=%b busy=%b ovf=%b, want 0/0/0", bus_out, busy, overflow);
        end
        #1 resetn = 1'b1;
        model_reset();
        @(posedge clock); #1;
        // store was cleared, so tag 3 reads back 0
        for (int i = 0; i < 5; i++) begin
            tick(i == 0 ? msg(2'b01, 3, 0) : 9'd0);
            n_checks++;
            if (bus_out !== exp_bus || (i == 2 && bus_out !== 9'b10_011_0000) || (i != 2 && bus_out !== 9'd0)) begin
                n_fail++;
                $display("FAIL basic_read[%0d]: got %b, want %b", i, bus_out, exp_bus);
            end
        end
        n_checks++;
        if (busy !== 1'b0 || exp_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_busy_after: got %b, want 0", busy);
        end
    endtask

    task automatic test_wb_then_read();
        logic [8:0] stim [6];
        do_reset();
        stim = '{msg(2'b11, 5, 10), msg(2'b01, 5, 0), 9'd0, 9'd0, 9'd0, 9'd0};
        for (int i = 0; i < 6; i++) begin
            tick(stim[i]);
            n_checks++;
            if (bus_out !== exp_bus || (i == 3 && bus_out !== 9'b10_101_1010)) begin
                n_fail++;
                $display("FAIL wb_then_read[%0d]: got %b, want %b", i, bus_out, exp_bus);
            end
        end
    endtask

    task automatic test_wb_during_wait();
        logic [8:0] stim [5];
        do_reset();
        stim = '{msg(2'b01, 2, 0), msg(2'b11, 2, 7), 9'd0, 9'd0, 9'd0};
        for (int i = 0; i < 5; i++) begin
            tick(stim[i]);
            n_checks++;
            if (bus_out !== exp_bus || (i == 2 && bus_out !== 9'b10_010_0111)) begin
                n_fail++;
                $display("FAIL wb_during_wait[%0d]: got %b, want %b", i, bus_out, exp_bus);
            end
        end
    endtask

    task automatic test_queueing();
        int         last_edge;
        int         n_rep;
        do_reset();
        last_edge = -1;
        n_rep     = 0;
        for (int i = 0; i < 16; i++) begin
            tick(i < 3 ? msg(2'b01, i + 1, 0) : 9'd0);
            n_checks++;
            if (bus_out !== exp_bus || busy !== exp_busy) begin
                n_fail++;
                $display("FAIL queue_cycle[%0d]: got bus=%b busy=%b, want bus=%b busy=%b", i, bus_out, busy, exp_bus, exp_busy);
            end
            if (bus_out != 9'd0) begin
                n_checks++;
                if (bus_out !== {2'b10, 3'(n_rep + 1), 4'h0} || (last_edge >= 0 && i - last_edge != L + 2)) begin
                    n_fail++;
                    $display("FAIL queue_order: reply %0d got %b at edge %0d (prev %0d), want tag %0d spaced %0d", n_rep, bus_out, i, last_edge, n_rep + 1, L + 2);
                end
                last_edge = i;
                n_rep++;
            end
        end
        n_checks++;
        if (n_rep != 3 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL queue_summary: got %0d replies ovf=%b, want 3 replies ovf=0", n_rep, overflow);
        end
    endtask

    task automatic test_overflow();
        int n_rep;
        do_reset();
        n_rep = 0;
        for (int i = 0; i < 24; i++) begin
            tick(i < 4 ? msg(2'b01, i, 9) : 9'd0);
            n_checks++;
            if (bus_out !== exp_bus || overflow !== exp_ovf) begin
                n_fail++;
                $display("FAIL ovf_cycle[%0d]: got bus=%b ovf=%b, want bus=%b ovf=%b", i, bus_out, overflow, exp_bus, exp_ovf);
            end
            if (bus_out != 9'd0) begin
                n_checks++;
                if (bus_out[6:4] !== 3'(n_rep)) begin
                    n_fail++;
                    $display("FAIL ovf_order: reply %0d got tag %0d, want %0d", n_rep, bus_out[6:4], n_rep);
                end
                n_rep++;
            end
        end
        n_checks++;
        if (n_rep != 3 || overflow !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_summary: got %0d replies ovf=%b busy=%b, want 3/1/0", n_rep, overflow, busy);
        end
        do_reset();
        #1;
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_cleared: got %b, want 0", overflow);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_random();
        logic [8:0] b;
        int         r;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 11);
            if (r < 4)       b = 9'd0;
            else if (r < 6)  b = msg(2'b01, $urandom_range(0, 7), $urandom_range(0, 15));
            else if (r < 10) b = msg(2'b11, $urandom_range(0, 7), $urandom_range(0, 15));
            else if (r < 11) b = msg(2'b10, $urandom_range(0, 7), $urandom_range(0, 15));
            else             b = msg(2'b00, $urandom_range(0, 7), $urandom_range(0, 15));
            if (i == 200) begin
                do_reset();
                @(posedge clock); #1;
            end
            tick(b);
            n_checks++;
            if (bus_out !== exp_bus || busy !== exp_busy || overflow !== exp_ovf) begin
                n_fail++;
                $display("FAIL random[%0d]: in=%b got bus=%b busy=%b ovf=%b, want bus=%b busy=%b ovf=%b",
                         i, b, bus_out, busy, overflow, exp_bus, exp_busy, exp_ovf);
            end
        end
    endtask

`ifdef MEM_RESP_STATS_EN
    task automatic test_stats();
        logic [8:0] stim [14];
        do_reset();
        stim = '{msg(2'b11, 1, 3), msg(2'b11, 2, 4), msg(2'b01, 1, 0), msg(2'b11, 6, 5),
                 9'd0, 9'd0, 9'd0, msg(2'b01, 6, 0), 9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0};
        for (int i = 0; i < 14; i++) tick(stim[i]);
        n_checks++;
        if (wb_cnt !== 8'd3 || rd_cnt !== 8'd2 || wb_cnt !== m_wb || rd_cnt !== m_rd) begin
            n_fail++;
            $display("FAIL stats_counts: got wb=%0d rd=%0d, want wb=3 rd=2", wb_cnt, rd_cnt);
        end
        do_reset();
        for (int i = 0; i < 256; i++) begin
            tick(msg(2'b11, i % 8, i % 16));
            if (i == 254) begin
                n_checks++;
                if (wb_cnt !== 8'd255) begin
                    n_fail++;
                    $display("FAIL stats_wb_255: got %0d, want 255", wb_cnt);
                end
            end
        end
        n_checks++;
        if (wb_cnt !== 8'd0 || m_wb !== 8'd0 || rd_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL stats_wrap: got wb=%0d rd=%0d, want wb=0 rd=0", wb_cnt, rd_cnt);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_in = 9'd0;
        resetn = 1'b0;
        test_reset();
        test_wb_then_read();
        test_wb_during_wait();
        test_queueing();
        test_overflow();
        test_random();
`ifdef MEM_RESP_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
